pio32_h2f: RTL and testbench

PIO32_H2F -- requirements
Module: pio32_h2f

---
 rtl/pio32_h2f.sv | 116 +++++++++++
 tb/tb_pio32_h2f.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pio32_h2f.sv
// pio32_h2f: host-to-fabric 32-bit PIO FIFO with first-word fall-through.
//
// The host pushes words with a single-cycle write strobe. The fabric
// consumes the head word through a valid/ready handshake. A push is
// accepted when the FIFO is not full, or when a pop frees an entry in
// the same cycle. A write that cannot be accepted is dropped and sets a
// sticky overflow flag. That flag clears on overflow_clr_in, unless a
// new drop happens in the same cycle.
//
// Ports:
//   clk              single clock, rising edge
//   rst              synchronous active-high reset
//   write_en_in      host write strobe
//   write_data_in    host write data
//   write_ack_out    registered pulse, one cycle after each accepted write
//   read_data_out    head-of-FIFO word (zero while empty)
//   read_valid_out   head word present
//   read_ready_in    fabric takes the head word when valid
//   count_out        current occupancy
//   full_out         count_out == DEPTH
//   overflow_out     sticky: a write was dropped
//   overflow_clr_in  clears overflow_out
module pio32_h2f #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         write_en_in,
  input  logic [31:0]                  write_data_in,
  output logic                         write_ack_out,
  output logic [31:0]                  read_data_out,
  output logic                         read_valid_out,
  input  logic                         read_ready_in,
  output logic [$clog2(DEPTH+1)-1:0]   count_out,
  output logic                         full_out,
  output logic                         overflow_out,
  input  logic                         overflow_clr_in
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          ack_q;
  logic          ovf_q;

  logic          pop;
  logic          push;
  logic          drop;

  // Status is decoded from the registered count only.
  always_comb begin
    read_valid_out = (count != '0);
    full_out       = (count == CW'(DEPTH));
    count_out      = count;
    write_ack_out  = ack_q;
    overflow_out   = ovf_q;
  end

  // A pop in the same cycle frees a slot, so a write into a full FIFO is
  // still accepted when the consumer is taking the head word.
  always_comb begin
    pop  = read_valid_out && read_ready_in;
    push = write_en_in && (!full_out || pop);
    drop = write_en_in && full_out && !pop;
  end

  // The storage array itself is not reset; the output mux below keeps
  // stale contents hidden while the FIFO is empty.
  always_comb begin
    read_data_out = '0;
    if (read_valid_out) begin
      read_data_out = mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= write_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ack_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      // DEPTH is a power of two, so the natural pointer wrap is DEPTH-1 -> 0.
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      ack_q <= push;
      // A new drop takes priority over the clear request.
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (overflow_clr_in) begin
        ovf_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pio32_h2f.sv
module tb_pio32_h2f;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          write_en_in;
  logic [31:0]   write_data_in;
  logic          write_ack_out;
  logic [31:0]   read_data_out;
  logic          read_valid_out;
  logic          read_ready_in;
  logic [CW-1:0] count_out;
  logic          full_out;
  logic          overflow_out;
  logic          overflow_clr_in;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [31:0] exp_q[$];

  pio32_h2f #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .write_en_in     (write_en_in),
    .write_data_in   (write_data_in),
    .write_ack_out   (write_ack_out),
    .read_data_out   (read_data_out),
    .read_valid_out  (read_valid_out),
    .read_ready_in   (read_ready_in),
    .count_out       (count_out),
    .full_out        (full_out),
    .overflow_out    (overflow_out),
    .overflow_clr_in (overflow_clr_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write one word; expect_accept says whether the word should enter the FIFO.
  task automatic wr(input logic [31:0] d, input bit expect_accept);
    write_en_in   = 1'b1;
    write_data_in = d;
    if (expect_accept) exp_q.push_back(d);
    tick();
    write_en_in = 1'b0;
  endtask

  // Monitor: a handshake seen mid-cycle means the head word leaves at the next edge.
  always @(negedge clk) begin
    if (!rst && read_valid_out && read_ready_in) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rd_unexpected: got %0h expected no word", read_data_out);
      end else begin
        check("rd_data", read_data_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    write_en_in = 1'b0;
    write_data_in = '0;
    read_ready_in = 1'b0;
    overflow_clr_in = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_count", 32'(count_out), 0);
    check("rst_valid", 32'(read_valid_out), 0);
    check("rst_full", 32'(full_out), 0);
    check("rst_data", read_data_out, 0);
    check("rst_ack", 32'(write_ack_out), 0);
    check("rst_ovf", 32'(overflow_out), 0);

    // Single write, fall-through on the next cycle.
    wr(32'hDEADBEEF, 1);
    check("fwft_valid", 32'(read_valid_out), 1);
    check("fwft_data", read_data_out, 32'hDEADBEEF);
    check("fwft_count", 32'(count_out), 1);
    check("fwft_ack", 32'(write_ack_out), 1);
    tick();
    check("fwft_ack_pulse", 32'(write_ack_out), 0);
    read_ready_in = 1'b1;
    tick();
    read_ready_in = 1'b0;
    check("fwft_drain_count", 32'(count_out), 0);
    check("fwft_drain_data", read_data_out, 0);

    // Fill to full, then a dropped write.
    for (int i = 1; i <= 4; i++) wr(32'(i), 1);
    check("fill_full", 32'(full_out), 1);
    check("fill_count", 32'(count_out), 4);
    check("fill_ack", 32'(write_ack_out), 1);
    wr(32'd5, 0);
    check("drop_ack", 32'(write_ack_out), 0);
    check("drop_ovf", 32'(overflow_out), 1);
    check("drop_count", 32'(count_out), 4);

    // Clear together with another drop: set wins. Then clear alone.
    overflow_clr_in = 1'b1;
    wr(32'd6, 0);
    check("clr_vs_set_ovf", 32'(overflow_out), 1);
    check("clr_vs_set_ack", 32'(write_ack_out), 0);
    tick();
    overflow_clr_in = 1'b0;
    check("clr_alone_ovf", 32'(overflow_out), 0);
    check("clr_alone_count", 32'(count_out), 4);

    // Drain 1..4.
    read_ready_in = 1'b1;
    repeat (4) tick();
    read_ready_in = 1'b0;
    check("drain_valid", 32'(read_valid_out), 0);
    check("drain_data", read_data_out, 0);
    check("drain_count", 32'(count_out), 0);

    // Refill; write while full with a pop in the same cycle.
    for (int i = 1; i <= 4; i++) wr(32'(i), 1);
    read_ready_in = 1'b1;
    wr(32'd9, 1);
    read_ready_in = 1'b0;
    check("pp_full_count", 32'(count_out), 4);
    check("pp_full_ovf", 32'(overflow_out), 0);
    check("pp_full_ack", 32'(write_ack_out), 1);
    read_ready_in = 1'b1;
    repeat (4) tick();
    check("pp_drain_count", 32'(count_out), 0);

    // Streaming with ready held: pointers wrap several times.
    for (int i = 0; i < 10; i++) begin
      wr(32'(i), 1);
      check("stream_count_le1", 32'(count_out <= CW'(1)), 1);
    end
    tick();
    check("stream_end_count", 32'(count_out), 0);

    // Ready while empty changes nothing.
    tick();
    check("idle_ready_count", 32'(count_out), 0);
    check("idle_ready_valid", 32'(read_valid_out), 0);
    read_ready_in = 1'b0;

    // Reset with three words held and write/pop requests pending.
    for (int i = 0; i < 3; i++) wr(32'hA0 + 32'(i), 1);
    check("pre_rst_count", 32'(count_out), 3);
    rst = 1'b1;
    write_en_in = 1'b1;
    write_data_in = 32'h55;
    read_ready_in = 1'b1;
    tick();
    exp_q.delete();
    rst = 1'b0;
    write_en_in = 1'b0;
    read_ready_in = 1'b0;
    check("rst_busy_count", 32'(count_out), 0);
    check("rst_busy_valid", 32'(read_valid_out), 0);
    check("rst_busy_ack", 32'(write_ack_out), 0);
    check("rst_busy_ovf", 32'(overflow_out), 0);
    check("rst_busy_data", read_data_out, 0);

    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
